// File: rtl/rice_core_pkg.sv
// rtl/rice_core_pkg.sv - rice core shared types, opcodes and pipeline bundles
`define RICE_CORE_DEFINE_TYPES(W) \
    typedef struct packed { \
        logic          valid; \
        logic [W-1:0]  pc; \
        logic [31:0]   inst; \
    } rice_core_if_result; \
    typedef struct packed { \
        logic          valid; \
        logic [4:0]    rd; \
        logic [W-1:0]  rd_value; \
    } rice_core_ex_result; \
    typedef struct packed { \
        logic                      valid; \
        logic [W-1:0]              pc; \
        logic [4:0]                rd; \
        logic [4:0]                rs1; \
        logic [4:0]                rs2; \
        logic [W-1:0]              rs1_value; \
        logic [W-1:0]              rs2_value; \
        logic [W-1:0]              imm_value; \
        rice_core_alu_operation    alu_operation; \
        rice_core_jamp_operation   jamp_operation; \
        rice_core_branch_operation branch_operation; \
        rice_core_memory_access    memory_access; \
    } rice_core_id_result;

package rice_core_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [1:0] {ALU_SOURCE1_RS1, ALU_SOURCE1_PC, ALU_SOURCE1_ZERO} rice_core_alu_source1;
    typedef enum logic [1:0] {ALU_SOURCE2_RS2, ALU_SOURCE2_IMM, ALU_SOURCE2_FOUR} rice_core_alu_source2;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
    } rice_core_alu_command;
    typedef enum logic [1:0] {ACCESS_NONE, ACCESS_READ, ACCESS_WRITE} rice_core_memory_access_type;
    // Mode encodings equal the load/store funct3 so the decoder can cast directly.
    typedef enum logic [2:0] {
        MODE_B = 3'b000, MODE_H = 3'b001, MODE_W = 3'b010, MODE_BU = 3'b100, MODE_HU = 3'b101
    } rice_core_memory_access_mode;

    typedef struct packed {
        rice_core_alu_source1 source1;
        rice_core_alu_source2 source2;
        rice_core_alu_command command;
    } rice_core_alu_operation;

    typedef struct packed {
        logic jal;
        logic jalr;
    } rice_core_jamp_operation;

    typedef struct packed {
        logic eq_ge;
        logic ne_lt;
    } rice_core_branch_operation;

    typedef struct packed {
        rice_core_memory_access_type access_type;
        rice_core_memory_access_mode access_mode;
    } rice_core_memory_access;

    `RICE_CORE_DEFINE_TYPES(XLEN)
endpackage

// File: rtl/rice_core_decoder.sv
// rtl/rice_core_decoder.sv - combinational RV32I decoder producing operand selects and a legal flag
module rice_core_decoder
    import rice_core_pkg::*;
(
    input  logic [31:0]               inst,
    output logic                      legal,
    output logic [4:0]                rd,
    output logic [4:0]                rs1,
    output logic [4:0]                rs2,
    output logic [XLEN-1:0]           imm_value,
    output rice_core_alu_operation    alu_operation,
    output rice_core_jamp_operation   jamp_operation,
    output rice_core_branch_operation branch_operation,
    output rice_core_memory_access    memory_access
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic is_op;
    logic alu_legal;
    rice_core_alu_command alu_command;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign is_op  = (opcode == OPCODE_OP);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Shared OP / OP-IMM command table; SUB only exists in the register form.
    always_comb begin
        alu_command = ALU_ADD;
        alu_legal   = !is_op || (funct7 == 7'h00);
        case (funct3)
            3'b000: begin
                if (is_op && funct7 == 7'h20) begin
                    alu_command = ALU_SUB;
                    alu_legal   = 1'b1;
                end
            end
            3'b001: begin
                alu_command = ALU_SLL;
                alu_legal   = (funct7 == 7'h00);
            end
            3'b010: alu_command = ALU_SLT;
            3'b011: alu_command = ALU_SLTU;
            3'b100: alu_command = ALU_XOR;
            3'b101: begin
                if (inst[30]) alu_command = ALU_SRA;
                else          alu_command = ALU_SRL;
                alu_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            3'b110: alu_command = ALU_OR;
            default: alu_command = ALU_AND;
        endcase
    end

    always_comb begin
        legal            = 1'b0;
        rd               = '0;
        rs1              = '0;
        rs2              = '0;
        imm_value        = '0;
        alu_operation    = '0;
        jamp_operation   = '0;
        branch_operation = '0;
        memory_access    = '0;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC: begin
                legal                 = 1'b1;
                rd                    = inst[11:7];
                imm_value             = imm_u;
                alu_operation.source1 = (opcode == OPCODE_LUI) ? ALU_SOURCE1_ZERO : ALU_SOURCE1_PC;
                alu_operation.source2 = ALU_SOURCE2_IMM;
            end
            OPCODE_JAL, OPCODE_JALR: begin
                legal                 = (opcode == OPCODE_JAL) || (funct3 == 3'b000);
                rd                    = inst[11:7];
                rs1                   = (opcode == OPCODE_JALR) ? inst[19:15] : 5'd0;
                imm_value             = (opcode == OPCODE_JAL) ? imm_j : imm_i;
                alu_operation.source1 = ALU_SOURCE1_PC;
                alu_operation.source2 = ALU_SOURCE2_FOUR;
                jamp_operation.jal    = (opcode == OPCODE_JAL);
                jamp_operation.jalr   = (opcode == OPCODE_JALR);
            end
            OPCODE_BRANCH: begin
                legal     = funct3[2] || !funct3[1];
                rs1       = inst[19:15];
                rs2       = inst[24:20];
                imm_value = imm_b;
                if (!funct3[2])     alu_operation.command = ALU_SUB;
                else if (funct3[1]) alu_operation.command = ALU_SLTU;
                else                alu_operation.command = ALU_SLT;
                // BNE/BLT/BLTU take when the compare is non-zero; the others when it is zero.
                branch_operation.ne_lt = funct3[0] ^ funct3[2];
                branch_operation.eq_ge = !(funct3[0] ^ funct3[2]);
            end
            OPCODE_LOAD, OPCODE_STORE: begin
                rs1                       = inst[19:15];
                alu_operation.source2     = ALU_SOURCE2_IMM;
                memory_access.access_mode = rice_core_memory_access_mode'(funct3);
                if (opcode == OPCODE_LOAD) begin
                    legal                     = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
                    rd                        = inst[11:7];
                    imm_value                 = imm_i;
                    memory_access.access_type = ACCESS_READ;
                end else begin
                    legal                     = !funct3[2] && (funct3[1:0] != 2'b11);
                    rs2                       = inst[24:20];
                    imm_value                 = imm_s;
                    memory_access.access_type = ACCESS_WRITE;
                end
            end
            OPCODE_OP_IMM, OPCODE_OP: begin
                legal                 = alu_legal;
                rd                    = inst[11:7];
                rs1                   = inst[19:15];
                rs2                   = is_op ? inst[24:20] : 5'd0;
                imm_value             = is_op ? '0 : imm_i;
                alu_operation.source2 = is_op ? ALU_SOURCE2_RS2 : ALU_SOURCE2_IMM;
                alu_operation.command = alu_command;
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/rice_core_register_file.sv
// rtl/rice_core_register_file.sv - x1..x31 with two write-first read ports and one write port
module rice_core_register_file
    import rice_core_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            clear,
    input  logic            write_enable,
    input  logic [4:0]      write_index,
    input  logic [XLEN-1:0] write_value,
    input  logic [4:0]      read_index_0,
    input  logic [4:0]      read_index_1,
    output logic [XLEN-1:0] read_value_0,
    output logic [XLEN-1:0] read_value_1
);
    logic [XLEN-1:0] registers [1:31];
    logic            write_live;

    assign write_live = write_enable && (write_index != 5'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) registers[i] <= '0;
        end else if (clear) begin
            for (int i = 1; i < 32; i++) registers[i] <= '0;
        end else if (write_live) begin
            registers[write_index] <= write_value;
        end
    end

    assign read_value_0 = (read_index_0 == 5'd0) ? '0 :
                          (write_live && write_index == read_index_0) ? write_value : registers[read_index_0];
    assign read_value_1 = (read_index_1 == 5'd0) ? '0 :
                          (write_live && write_index == read_index_1) ? write_value : registers[read_index_1];
endmodule

// File: rtl/rice_core_id_stage.sv
// rtl/rice_core_id_stage.sv - decode stage: register-file read and registered id_result toward execute
module rice_core_id_stage
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  rice_core_if_result if_result,
    input  logic               stall,
    input  logic               flush,
    input  rice_core_ex_result ex_result,
    output rice_core_id_result id_result
);
    logic                      legal;
    logic [4:0]                rd, rs1, rs2;
    logic [XLEN-1:0]           imm_value, rs1_value, rs2_value;
    rice_core_alu_operation    alu_operation;
    rice_core_jamp_operation   jamp_operation;
    rice_core_branch_operation branch_operation;
    rice_core_memory_access    memory_access;

    rice_core_decoder u_decoder (
        .inst             (if_result.inst),
        .legal            (legal),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm_value        (imm_value),
        .alu_operation    (alu_operation),
        .jamp_operation   (jamp_operation),
        .branch_operation (branch_operation),
        .memory_access    (memory_access)
    );

    // Write-back is independent of flush: the retiring instruction is older than the flushed one.
    rice_core_register_file u_register_file (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .clear        (!i_enable),
        .write_enable (ex_result.valid && !stall),
        .write_index  (ex_result.rd),
        .write_value  (ex_result.rd_value),
        .read_index_0 (rs1),
        .read_index_1 (rs2),
        .read_value_0 (rs1_value),
        .read_value_1 (rs2_value)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            id_result <= '0;
        end else if (!i_enable) begin
            id_result <= '0;
        end else if (flush) begin
            id_result.valid <= 1'b0;
        end else if (!stall) begin
            id_result.valid            <= if_result.valid && legal;
            id_result.pc               <= if_result.pc;
            id_result.rd               <= rd;
            id_result.rs1              <= rs1;
            id_result.rs2              <= rs2;
            id_result.rs1_value        <= rs1_value;
            id_result.rs2_value        <= rs2_value;
            id_result.imm_value        <= imm_value;
            id_result.alu_operation    <= alu_operation;
            id_result.jamp_operation   <= jamp_operation;
            id_result.branch_operation <= branch_operation;
            id_result.memory_access    <= memory_access;
        end
    end
endmodule

// File: tb/tb_rice_core_id_stage.sv
// tb/tb_rice_core_id_stage.sv - directed and randomized bench for the rice core decode stage
module tb_rice_core_id_stage;
    import rice_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    rice_core_if_result if_result = '0;
    rice_core_ex_result ex_result = '0;
    rice_core_id_result id_result;

    int errors = 0;
    int checks = 0;
    logic [31:0] regs_m [32];
    rice_core_id_result exp_r;

    always #5 clk = ~clk;

    rice_core_id_stage #(.XLEN(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (en),
        .if_result (if_result),
        .stall     (stall),
        .flush     (flush),
        .ex_result (ex_result),
        .id_result (id_result)
    );

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (ex_result.valid && ex_result.rd == idx && !stall) return ex_result.rd_value;
        return regs_m[idx];
    endfunction

    function automatic rice_core_alu_command alu_for(input logic [2:0] f3, input logic b30);
        case (f3)
            3'd0: return ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: if (b30) return ALU_SRA; else return ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic rice_core_id_result model_decode(input logic [31:0] pc, input logic [31:0] inst, input logic iv);
        rice_core_id_result r;
        logic ok, use_rd, use_rs1, use_rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        r = '0; ok = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        f3 = inst[14:12];
        f7 = inst[31:25];
        imm_i = 32'($signed(inst) >>> 20);
        imm_s = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
        imm_b = (32'($signed(inst) >>> 31) << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        imm_u = inst & 32'hFFFFF000;
        imm_j = (32'($signed(inst) >>> 31) << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        case (inst[6:0])
            7'h37: begin ok = 1; use_rd = 1; r.imm_value = imm_u;
                r.alu_operation.source1 = ALU_SOURCE1_ZERO; r.alu_operation.source2 = ALU_SOURCE2_IMM; end
            7'h17: begin ok = 1; use_rd = 1; r.imm_value = imm_u;
                r.alu_operation.source1 = ALU_SOURCE1_PC; r.alu_operation.source2 = ALU_SOURCE2_IMM; end
            7'h6F: begin ok = 1; use_rd = 1; r.imm_value = imm_j; r.jamp_operation.jal = 1;
                r.alu_operation.source1 = ALU_SOURCE1_PC; r.alu_operation.source2 = ALU_SOURCE2_FOUR; end
            7'h67: begin ok = (f3 == 0); use_rd = 1; use_rs1 = 1; r.imm_value = imm_i; r.jamp_operation.jalr = 1;
                r.alu_operation.source1 = ALU_SOURCE1_PC; r.alu_operation.source2 = ALU_SOURCE2_FOUR; end
            7'h63: begin ok = 1; use_rs1 = 1; use_rs2 = 1; r.imm_value = imm_b;
                case (f3)
                    3'd0: begin r.alu_operation.command = ALU_SUB;  r.branch_operation.eq_ge = 1; end
                    3'd1: begin r.alu_operation.command = ALU_SUB;  r.branch_operation.ne_lt = 1; end
                    3'd4: begin r.alu_operation.command = ALU_SLT;  r.branch_operation.ne_lt = 1; end
                    3'd5: begin r.alu_operation.command = ALU_SLT;  r.branch_operation.eq_ge = 1; end
                    3'd6: begin r.alu_operation.command = ALU_SLTU; r.branch_operation.ne_lt = 1; end
                    3'd7: begin r.alu_operation.command = ALU_SLTU; r.branch_operation.eq_ge = 1; end
                    default: ok = 0;
                endcase end
            7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); use_rd = 1; use_rs1 = 1;
                r.imm_value = imm_i; r.alu_operation.source2 = ALU_SOURCE2_IMM;
                r.memory_access.access_type = ACCESS_READ; r.memory_access.access_mode = rice_core_memory_access_mode'(f3); end
            7'h23: begin ok = (f3 <= 2); use_rs1 = 1; use_rs2 = 1;
                r.imm_value = imm_s; r.alu_operation.source2 = ALU_SOURCE2_IMM;
                r.memory_access.access_type = ACCESS_WRITE; r.memory_access.access_mode = rice_core_memory_access_mode'(f3); end
            7'h13: begin use_rd = 1; use_rs1 = 1; r.imm_value = imm_i; r.alu_operation.source2 = ALU_SOURCE2_IMM;
                r.alu_operation.command = alu_for(f3, inst[30]);
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1; end
            7'h33: begin use_rd = 1; use_rs1 = 1; use_rs2 = 1;
                if (f3 == 0 && f7 == 7'h20) r.alu_operation.command = ALU_SUB;
                else r.alu_operation.command = alu_for(f3, inst[30]);
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
            default: ok = 0;
        endcase
        r.rd  = use_rd  ? inst[11:7]  : 5'd0;
        r.rs1 = use_rs1 ? inst[19:15] : 5'd0;
        r.rs2 = use_rs2 ? inst[24:20] : 5'd0;
        r.rs1_value = model_read(r.rs1);
        r.rs2_value = model_read(r.rs2);
        r.pc = pc;
        r.valid = iv && ok;
        return r;
    endfunction

    task automatic tick();
        rice_core_id_result nxt;
        nxt = model_decode(if_result.pc, if_result.inst, if_result.valid);
        @(posedge clk);
        if (!en) begin
            exp_r = '0;
            for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        end else begin
            if (ex_result.valid && ex_result.rd != 0 && !stall) regs_m[ex_result.rd] = ex_result.rd_value;
            if (flush) exp_r.valid = 1'b0;
            else if (!stall) exp_r = nxt;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        if_result = '{valid: 1'b1, pc: pc, inst: inst};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; stall = 0; flush = 0; ex_result = '0; if_result = '0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        exp_r = '0;
        repeat (2) @(negedge clk);
        checks++; if (id_result !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", id_result); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drive(32'h100, 32'h00500093);
        tick();
        checks++; if ({id_result.valid, id_result.pc, id_result.rd, id_result.rs1, id_result.rs2, id_result.imm_value} !== {1'b1, 32'h100, 5'd1, 5'd0, 5'd0, 32'd5})
            begin errors++; $display("FAIL addi_fields got %h", {id_result.valid, id_result.pc, id_result.rd, id_result.rs1, id_result.rs2, id_result.imm_value}); end
        checks++; if ({id_result.alu_operation.source1, id_result.alu_operation.source2, id_result.alu_operation.command} !== {ALU_SOURCE1_RS1, ALU_SOURCE2_IMM, ALU_ADD})
            begin errors++; $display("FAIL addi_alu got %h exp RS1/IMM/ADD", id_result.alu_operation); end
    endtask

    task automatic test_bypass();
        ex_result = '{valid: 1'b1, rd: 5'd3, rd_value: 32'hDEAD};
        drive(32'h104, 32'h00318233);
        tick();
        checks++; if ({id_result.rs1_value, id_result.rs2_value, id_result.rd} !== {32'hDEAD, 32'hDEAD, 5'd4})
            begin errors++; $display("FAIL bypass got %h %h rd %0d exp dead dead 4", id_result.rs1_value, id_result.rs2_value, id_result.rd); end
        ex_result = '0;
        tick();
        checks++; if (id_result.rs1_value !== 32'hDEAD) begin errors++; $display("FAIL regfile_hold got %h exp dead", id_result.rs1_value); end
        ex_result = '{valid: 1'b1, rd: 5'd0, rd_value: 32'hBEEF};
        drive(32'h108, 32'h00000233);
        tick();
        checks++; if ({id_result.rs1_value, id_result.rs2_value} !== 64'd0) begin errors++; $display("FAIL x0_bypass got %h exp 0", id_result.rs1_value); end
        ex_result = '0;
        tick();
        checks++; if (id_result.rs2_value !== 32'd0) begin errors++; $display("FAIL x0_write got %h exp 0", id_result.rs2_value); end
    endtask

    task automatic test_stall_flush();
        drive(32'h200, 32'h00500093);
        tick();
        stall = 1'b1;
        ex_result = '{valid: 1'b1, rd: 5'd9, rd_value: 32'h77};
        for (int i = 0; i < 3; i++) begin
            drive(32'h300 + 32'(i * 4), 32'h123452B7 + 32'(i << 12));
            tick();
            checks++; if ({id_result.valid, id_result.pc, id_result.imm_value} !== {1'b1, 32'h200, 32'd5})
                begin errors++; $display("FAIL stall_hold%0d got pc %h imm %h", i, id_result.pc, id_result.imm_value); end
        end
        stall = 1'b0; ex_result = '0;
        drive(32'h210, 32'h00948533);
        tick();
        checks++; if ({id_result.valid, id_result.rs1_value} !== {1'b1, 32'd0})
            begin errors++; $display("FAIL stalled_write got %h exp valid 0-value", {id_result.valid, id_result.rs1_value}); end
        stall = 1'b1; flush = 1'b1;
        drive(32'h214, 32'h00500093);
        tick();
        checks++; if (id_result.valid !== 1'b0) begin errors++; $display("FAIL stall_flush got valid %b exp 0", id_result.valid); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_branch_jump();
        drive(32'h400, 32'hFE20DCE3);
        tick();
        checks++; if ({id_result.valid, id_result.imm_value, id_result.rd, id_result.alu_operation.command, id_result.branch_operation}
                      !== {1'b1, 32'hFFFFFFF8, 5'd0, ALU_SLT, 2'b10})
            begin errors++; $display("FAIL bge got imm %h rd %0d cmd %0d br %b", id_result.imm_value, id_result.rd, id_result.alu_operation.command, id_result.branch_operation); end
        drive(32'h404, 32'h001000EF);
        tick();
        checks++; if ({id_result.valid, id_result.imm_value, id_result.rd, id_result.alu_operation.source1, id_result.alu_operation.source2, id_result.jamp_operation}
                      !== {1'b1, 32'h800, 5'd1, ALU_SOURCE1_PC, ALU_SOURCE2_FOUR, 2'b10})
            begin errors++; $display("FAIL jal got imm %h rd %0d alu %h jamp %b", id_result.imm_value, id_result.rd, id_result.alu_operation, id_result.jamp_operation); end
        drive(32'h408, 32'h123452B7);
        tick();
        checks++; if ({id_result.valid, id_result.imm_value, id_result.rd, id_result.rs1, id_result.alu_operation.source1, id_result.alu_operation.source2}
                      !== {1'b1, 32'h12345000, 5'd5, 5'd0, ALU_SOURCE1_ZERO, ALU_SOURCE2_IMM})
            begin errors++; $display("FAIL lui got imm %h rd %0d rs1 %0d", id_result.imm_value, id_result.rd, id_result.rs1); end
        drive(32'h40C, 32'h0000000F);
        tick();
        checks++; if (id_result.valid !== 1'b0) begin errors++; $display("FAIL fence got valid %b exp 0", id_result.valid); end
        drive(32'h410, 32'h00000073);
        tick();
        checks++; if (id_result.valid !== 1'b0) begin errors++; $display("FAIL ecall got valid %b exp 0", id_result.valid); end
    endtask

    task automatic test_reset_midstream();
        ex_result = '{valid: 1'b1, rd: 5'd7, rd_value: 32'h55};
        drive(32'h500, 32'h00500093);
        tick();
        ex_result = '0;
        drive(32'h504, 32'h00738433);
        tick();
        checks++; if ({id_result.valid, id_result.rs1_value} !== {1'b1, 32'h55}) begin errors++; $display("FAIL pre_reset got %h exp 1_00000055", {id_result.valid, id_result.rs1_value}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (id_result.valid !== 1'b0) begin errors++; $display("FAIL async_reset got valid %b exp 0", id_result.valid); end
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        exp_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if ({id_result.valid, id_result.rs1_value} !== {1'b1, 32'd0}) begin errors++; $display("FAIL post_reset got %h exp 1_00000000", {id_result.valid, id_result.rs1_value}); end
    endtask

    task automatic test_enable();
        ex_result = '{valid: 1'b1, rd: 5'd7, rd_value: 32'h66};
        tick();
        ex_result = '0;
        tick();
        checks++; if (id_result.rs1_value !== 32'h66) begin errors++; $display("FAIL pre_disable got %h exp 66", id_result.rs1_value); end
        en = 1'b0;
        tick();
        checks++; if (id_result !== '0) begin errors++; $display("FAIL disable_clear got %h exp 0", id_result); end
        en = 1'b1;
        tick();
        checks++; if ({id_result.valid, id_result.rs1_value} !== {1'b1, 32'd0}) begin errors++; $display("FAIL post_disable got %h exp 1_00000000", {id_result.valid, id_result.rs1_value}); end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        logic [6:0] op;
        x = $urandom;
        case ($urandom % 12)
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
            8: op = 7'h33;  9: op = 7'h0F;  10: op = 7'h73;
            default: op = 7'($urandom);
        endcase
        x[6:0] = op;
        x[19:15] = 5'($urandom % 8);
        x[24:20] = 5'($urandom % 8);
        case ($urandom % 3)
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            default: ;
        endcase
        return x;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 7) == 0;
            en = ($urandom % 60) != 0;
            ex_result = '{valid: 1'($urandom % 2), rd: 5'($urandom % 8), rd_value: $urandom};
            if_result = '{valid: ($urandom % 8) != 0, pc: $urandom & 32'hFFFFFFFC, inst: rand_inst()};
            tick();
            checks++;
            if (exp_r.valid ? (id_result !== exp_r) : (id_result.valid !== 1'b0))
                begin errors++; $display("FAIL random%0d got %h exp %h", n, id_result, exp_r); end
        end
        stall = 0; flush = 0; en = 1; ex_result = '0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_stall_flush();
        test_branch_jump();
        test_reset_midstream();
        test_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rice_core_id_stage.md
Name: rice_core_id_stage

Overview:
- Decode stage of the rice core pipeline, directly upstream of the execute stage.
- Accepts fetched instructions (pc, inst) from the fetch stage and decodes RV32I.
- Reads rs1/rs2 from an internal 31-entry register file, which is written back from the execute stage's ex_result.
- Registers the decoded bundle (id_result) toward execute. Honours the pipeline stall and flush signals.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  core enable; when low, the pipeline register and register file are cleared.
- pipeline_if  modport id_stage  bundle  pipeline interface, with the following members:
  - if_result  input: valid, pc, inst[31:0].
  - stall  input  1: from execute.
  - flush  input  1: from execute.
  - ex_result  input: valid, rd, rd_value; register-file write source.
  - id_result  output: valid, pc, rd, rs1, rs2, rs1_value, rs2_value, imm_value, alu_operation, jamp_operation, branch_operation, memory_access.

Behaviour:
- Reset (or i_enable low): id_result <= all-zero (valid=0, operations NONE), and every register x1..x31 <= 0. Reset mid-operation discards any in-flight instruction.
- Latency: one cycle, if_result to id_result. Update priority order:
  1. flush=1 -> id_result.valid <= 0 next edge; other fields don't-care. Flush takes priority over stall.
  2. stall=1 -> id_result held bit-exact. The fetch stage also holds on stall, so no instruction is lost.
  3. otherwise -> id_result <= decode(if_result); valid = if_result.valid && legal.
- Illegal or unsupported opcode (FENCE, SYSTEM, unknown): issued as a bubble (valid=0). No trap.
- Register file:
  - x0 always reads 0.
  - Write at the clock edge when ex_result.valid && rd!=0 and not stalled.
  - Same-cycle read of the register being written returns ex_result.rd_value (write-first bypass).
  - Writes occur even during flush.
- Immediates: I/S/B/U/J formats, sign-extended to XLEN. B and J immediates carry a zero lsb. U immediate is inst[31:12]<<12.
- ALU operand selects:
  - source1: RS1 / PC / ZERO.
  - source2: RS2 / IMM / FOUR.
  - command: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA.
- Mapping:
  - LUI: ZERO+IMM.
  - AUIPC: PC+IMM.
  - JAL/JALR: PC+FOUR, with jamp.jal / jamp.jalr set respectively.
  - OP-IMM/OP: per funct3/funct7. SRAI/SRA are selected by inst[30]; SUB is valid only for OP.
- Branch encoding (execute flushes on eq_ge && alu==0 or ne_lt && alu!=0):

  | Instruction | ALU command | Branch flag |
  |---|---|---|
  | BEQ | SUB | eq_ge |
  | BNE | SUB | ne_lt |
  | BLT | SLT | ne_lt |
  | BGE | SLT | eq_ge |
  | BLTU | SLTU | ne_lt |
  | BGEU | SLTU | eq_ge |

  Branches set rd=0.
- Memory access:
  - LOAD: access_type READ; mode from funct3 (B/H/W, BU/HU).
  - STORE: access_type WRITE, rd=0.
  - Any other funct3 encoding is illegal.
- rs1/rs2 fields are forced to 0 for formats without them (U, J; rs2 also for I), so execute-stage forwarding never matches spuriously.

Decomposition:
- rice_core_pkg gains (extending existing types):
  - opcode constants;
  - alu source1/source2 enums;
  - memory access mode enum;
  - the rice_core_id_result struct via the rice_core_define_types macro.
- Sub-modules:
  - rice_core_decoder: combinational, inst + pc -> decoded fields and legal flag.
  - rice_core_register_file: 2 read ports, 1 write port, async reset, write-first bypass.

Test Plan:
- Decode: inst 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle valid=1, rd=1, rs1=0, imm=5, ALU ADD RS1/IMM.
- Write-back/bypass: ex_result{valid,rd=3,0xDEAD} in the same cycle as decoding add x4,x3,x3 -> rs1_value=rs2_value=0xDEAD. A write to rd=0 leaves x0 reading 0.
- Stall/flush priority:
  - Stall held 3 cycles with changing if_result -> id_result unchanged.
  - Stall and flush together -> valid=0 next cycle.
- Branch: bge x1,x2,-8 (0xFE20DCE3) -> SLT, eq_ge=1, imm=0xFFFFFFF8, rd=0.
- Jumps: jal x1,+2048 -> PC+FOUR, jamp.jal=1, imm=0x800; lui x5,0x12345 -> imm=0x12345000, rs1=0.
- Reset: assert i_rst_n low mid-stream -> id_result.valid=0 immediately and all registers read 0 after release. The same holds for i_enable=0 at a clock edge.
